// File: rtl/lsd_adc_pkg.sv
// rtl/lsd_adc_pkg.sv - shared types and constants for the LSD ADC conversion sequencer
package lsd_adc_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_WR   = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_RD   = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   localparam logic MODE_WR_RD = 1'b1;

   typedef struct packed {
      logic       ofl;
      logic [7:0] data;
   } sample_t;

   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/lsd_adc_if.sv
// rtl/lsd_adc_if.sv - sample stream between the ADC sequencer and its consumer
interface lsd_adc_if;

   logic [7:0] sample_data;
   logic       sample_ofl;
   logic       sample_valid;
   logic       sample_ready;

   modport master (
      output sample_data,
      output sample_ofl,
      output sample_valid,
      input  sample_ready
   );

   modport slave (
      input  sample_data,
      input  sample_ofl,
      input  sample_valid,
      output sample_ready
   );

endinterface

// File: rtl/lsd_sync2.sv
// rtl/lsd_sync2.sv - two-flop synchronizer with configurable reset value
module lsd_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/lsd_adc_reader.sv
// rtl/lsd_adc_reader.sv - periodic WR-RD conversion sequencer for the parallel LSD ADC
// Optional LSD_ADC_AVG_EN: publish the truncated mean of every 4 raw samples.
module lsd_adc_reader
   import lsd_adc_pkg::*;
#(
   parameter int SAMPLE_PERIOD = 12000,
   parameter int WR_LOW_CYC    = 8,
   parameter int RD_LOW_CYC    = 4,
   parameter int TIMEOUT_CYC   = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lsd_adc_int,
   input  logic [7:0] lsd_adc_d,
   input  logic       lsd_adc_ofl,
   output logic       lsd_adc_cs,
   output logic       lsd_adc_rd,
   output logic       lsd_adc_wr_rdy,
   output logic       lsd_adc_mode,
   lsd_adc_if.master  smp,
   output logic       overrun,
   output logic       timeout
);

   localparam int PH_MAX   = (TIMEOUT_CYC > WR_LOW_CYC) ?
                             ((TIMEOUT_CYC > RD_LOW_CYC) ? TIMEOUT_CYC : RD_LOW_CYC) :
                             ((WR_LOW_CYC > RD_LOW_CYC) ? WR_LOW_CYC : RD_LOW_CYC);
   localparam int PHASE_W  = cnt_w(PH_MAX);
   localparam int PERIOD_W = cnt_w(SAMPLE_PERIOD);

   localparam logic [PHASE_W-1:0]  PH_WR_LAST  = PHASE_W'(WR_LOW_CYC - 1);
   localparam logic [PHASE_W-1:0]  PH_RD_LAST  = PHASE_W'(RD_LOW_CYC - 1);
   localparam logic [PHASE_W-1:0]  PH_TO_LAST  = PHASE_W'(TIMEOUT_CYC - 1);
   localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(SAMPLE_PERIOD - 1);

   logic [2:0]          r_state;
   logic [2:0]          w_state_nxt;
   logic [PHASE_W-1:0]  r_phase;
   logic [PERIOD_W-1:0] r_period;
   logic                r_cs;
   logic                r_rd;
   logic                r_wr;
   logic                r_overrun;
   logic                r_timeout;
   logic                r_valid;
   sample_t             r_cap;
   sample_t             r_out;
   logic                w_int_s;
   logic                w_tick;
   logic                w_timeout_hit;
   logic                w_pub;
   sample_t             w_pub_sample;

   lsd_sync2 #(.RST_VAL(1'b1)) u_int_sync (
      .clk     (clk),
      .rst     (rst),
      .i_async (lsd_adc_int),
      .o_sync  (w_int_s)
   );

   assign w_tick        = (r_period == PERIOD_LAST);
   assign w_timeout_hit = (r_state == ST_WAIT) && w_int_s && (r_phase == PH_TO_LAST);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_tick)                  w_state_nxt = ST_WR;
         ST_WR:   if (r_phase == PH_WR_LAST)   w_state_nxt = ST_WAIT;
         ST_WAIT: if (!w_int_s)                w_state_nxt = ST_RD;
                  else if (w_timeout_hit)      w_state_nxt = ST_IDLE;
         ST_RD:   if (r_phase == PH_RD_LAST)   w_state_nxt = ST_DONE;
         ST_DONE:                              w_state_nxt = ST_IDLE;
         default:                              w_state_nxt = ST_IDLE;
      endcase
   end

   // Strobes are registered from the next state so they track the FSM exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_phase   <= '0;
         r_period  <= '0;
         r_cs      <= 1'b1;
         r_rd      <= 1'b1;
         r_wr      <= 1'b1;
         r_timeout <= 1'b0;
         r_cap     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_phase   <= (w_state_nxt != r_state || r_state == ST_IDLE) ? '0 : r_phase + 1'b1;
         r_period  <= w_tick ? '0 : r_period + 1'b1;
         r_cs      <= !(w_state_nxt == ST_WR || w_state_nxt == ST_RD);
         r_wr      <= (w_state_nxt != ST_WR);
         r_rd      <= (w_state_nxt != ST_RD);
         r_timeout <= w_timeout_hit;
         if (r_state == ST_RD && w_state_nxt == ST_DONE)
            r_cap <= '{ofl: lsd_adc_ofl, data: lsd_adc_d};
      end
   end

`ifdef LSD_ADC_AVG_EN
   logic [9:0] r_acc;
   logic [1:0] r_acc_cnt;
   logic       r_acc_ofl;
   logic [9:0] w_sum;

   assign w_sum        = r_acc + {2'b00, r_cap.data};
   assign w_pub        = (r_state == ST_DONE) && (r_acc_cnt == 2'd3);
   assign w_pub_sample = '{ofl: r_acc_ofl | r_cap.ofl, data: w_sum[9:2]};

   always_ff @(posedge clk) begin
      if (rst || w_timeout_hit || w_pub) begin
         r_acc     <= '0;
         r_acc_cnt <= '0;
         r_acc_ofl <= 1'b0;
      end else if (r_state == ST_DONE) begin
         r_acc     <= w_sum;
         r_acc_cnt <= r_acc_cnt + 2'd1;
         r_acc_ofl <= r_acc_ofl | r_cap.ofl;
      end
   end
`else
   assign w_pub        = (r_state == ST_DONE);
   assign w_pub_sample = r_cap;
`endif

   // A publish always wins over an accept; overrun only when the old sample was never taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out     <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (w_pub) begin
            r_out     <= w_pub_sample;
            r_valid   <= 1'b1;
            r_overrun <= r_valid && !smp.sample_ready;
         end else if (r_valid && smp.sample_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign lsd_adc_cs       = r_cs;
   assign lsd_adc_rd       = r_rd;
   assign lsd_adc_wr_rdy   = r_wr;
   assign lsd_adc_mode     = MODE_WR_RD;
   assign smp.sample_data  = r_out.data;
   assign smp.sample_ofl   = r_out.ofl;
   assign smp.sample_valid = r_valid;
   assign overrun          = r_overrun;
   assign timeout          = r_timeout;

endmodule
